// File: rtl/ps2_kbd_device.sv
// ps2_kbd_device: PS/2 keyboard emulator. Turns hps_io ps2_key toggle events
// into set-2 scancode frames on an open-drain clock/data pair. It also receives
// host commands (FF reset, ED set-LEDs, anything else) and answers them.
//
// Ports:
//   clk, reset_n               system clock, async active-low reset
//   ps2_key[10:0]              [10] toggle, [9] pressed, [8] extended, [7:0] code
//   ps2_clk_in, ps2_data_in    sensed wired-AND lines (asynchronous)
//   ps2_clk_out, ps2_data_out  0 = pull low, 1 = release
//   leds[2:0]                  last LED byte received after an ED command
//   busy                       FSM not idle
//   overflow                   one-cycle pulse when a key event is dropped
module ps2_kbd_device #(
  parameter int CLK_HZ     = 28636000,
  parameter int PS2_HZ     = 12500,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_out,
  output logic        ps2_data_out,
  output logic [2:0]  leds,
  output logic        busy,
  output logic        overflow
);
  localparam int H  = CLK_HZ / (2 * PS2_HZ);
  localparam int TW = $clog2(2 * H + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] H_L   = TW'(H);
  localparam logic [TW-1:0] H_M1  = TW'(H - 1);
  localparam logic [TW-1:0] H2    = TW'(2 * H);
  localparam logic [TW-1:0] H2_M1 = TW'(2 * H - 1);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_TX_GAP, S_RX_REQ, S_RX, S_RX_ACK} state_t;

  state_t          r_state, w_state_n;
  logic [1:0]      r_clk_s, r_dat_s;
  logic [TW-1:0]   r_hi, r_lo, r_tmr;
  logic            r_ph;
  logic [3:0]      r_bit;
  logic [10:0]     r_txf;
  logic            r_src_rsp;
  logic [8:0]      r_rxsh;
  logic [7:0]      r_rsp0, r_rsp1;
  logic [1:0]      r_rsp_n;
  logic            r_arm, r_ovf, r_tog, r_tog_vld;
  logic [2:0]      r_leds;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [AW:0]     r_cnt;

  logic            w_clk, w_dat, w_tdone, w_pend, w_start, w_pop, w_samp, w_rx_done;
  logic            w_evt, w_push, w_drop, w_flush, w_par_ok, w_pop_fifo;
  logic [7:0]      w_seq0, w_seq1, w_seq2, w_src, w_rx_byte;
  logic [1:0]      w_len;
  logic [AW:0]     w_free;

  assign w_clk      = r_clk_s[1];
  assign w_dat      = r_dat_s[1];
  assign w_tdone    = (r_tmr == H_M1);
  assign w_pend     = (r_rsp_n != 2'd0) || (r_cnt != '0);
  assign w_src      = (r_rsp_n != 2'd0) ? r_rsp0 : r_mem[r_rp];
  assign w_rx_byte  = r_rxsh[7:0];
  assign w_par_ok   = ^r_rxsh;
  assign w_flush    = w_rx_done && w_par_ok && !r_arm && (w_rx_byte == 8'hFF);
  assign w_pop_fifo = w_pop && !r_src_rsp;

  assign busy         = (r_state != S_IDLE);
  assign overflow     = r_ovf;
  assign leds         = r_leds;
  assign ps2_clk_out  = !((r_state == S_TX && r_ph) ||
                          ((r_state == S_RX || r_state == S_RX_ACK) && !r_ph));
  assign ps2_data_out = (r_state == S_TX) ? r_txf[0] : (r_state != S_RX_ACK);

  // line synchronizers and idle-line level counters (saturating)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s <= 2'b11; r_dat_s <= 2'b11; r_hi <= '0; r_lo <= '0;
    end else begin
      r_clk_s <= {r_clk_s[0], ps2_clk_in};
      r_dat_s <= {r_dat_s[0], ps2_data_in};
      if (w_clk) begin
        r_hi <= (r_hi == H2) ? r_hi : r_hi + 1'b1;
        r_lo <= '0;
      end else begin
        r_lo <= (r_lo == H_L) ? r_lo : r_lo + 1'b1;
        r_hi <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_start   = 1'b0;
    w_pop     = 1'b0;
    w_samp    = 1'b0;
    w_rx_done = 1'b0;
    case (r_state)
      // r_tmr >= 3 lets the data synchronizer catch up after we release data
      // on an aborted frame, so our own stale low is not mistaken for a request.
      S_IDLE:
        if (r_lo == H_L && !w_dat && r_tmr >= TW'(3)) w_state_n = S_RX_REQ;
        else if (w_pend && r_hi == H2) begin w_state_n = S_TX; w_start = 1'b1; end
      S_TX:
        if (w_tdone) begin
          if (!r_ph && r_bit != 4'd10 && !w_clk) w_state_n = S_IDLE;   // host inhibit
          else if (r_ph && r_bit == 4'd10) begin w_state_n = S_TX_GAP; w_pop = 1'b1; end
        end
      S_TX_GAP: if (r_tmr == H2_M1) w_state_n = S_IDLE;
      S_RX_REQ: if (w_clk) w_state_n = S_RX;
      S_RX:
        if (w_tdone) begin
          if (!r_ph) w_samp = 1'b1;
          else if (r_bit == 4'd9) begin w_state_n = S_RX_ACK; w_rx_done = 1'b1; end
        end
      S_RX_ACK: if (w_tdone && r_ph) w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  // phase timer, half-period phase and bit index; shift registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmr <= '0; r_ph <= 1'b0; r_bit <= '0;
      r_txf <= '1; r_src_rsp <= 1'b0; r_rxsh <= '0;
    end else begin
      if (w_state_n != r_state) begin
        r_tmr <= '0; r_ph <= 1'b0; r_bit <= '0;
      end else if (r_state == S_TX || r_state == S_RX || r_state == S_RX_ACK) begin
        if (w_tdone) begin
          r_tmr <= '0;
          r_ph  <= ~r_ph;
          if (r_ph) r_bit <= r_bit + 4'd1;
        end else r_tmr <= r_tmr + 1'b1;
      end else if (r_state == S_RX_REQ) r_tmr <= '0;
      else r_tmr <= (r_tmr == H2) ? r_tmr : r_tmr + 1'b1;

      if (w_start) begin
        r_txf     <= {1'b1, ~^w_src, w_src, 1'b0};
        r_src_rsp <= (r_rsp_n != 2'd0);
      end else if (r_state == S_TX && w_tdone && r_ph) r_txf <= {1'b1, r_txf[10:1]};

      // stop bit (index 9) is not kept
      if (w_samp && r_bit != 4'd9) r_rxsh <= {w_dat, r_rxsh[8:1]};
    end
  end

  // host command decode and response register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp0 <= '0; r_rsp1 <= '0; r_rsp_n <= '0; r_arm <= 1'b0; r_leds <= '0;
    end else if (w_rx_done) begin
      r_rsp0 <= 8'hFA; r_rsp_n <= 2'd1;
      if (!w_par_ok) r_rsp0 <= 8'hFE;
      else if (r_arm) begin
        r_leds <= w_rx_byte[2:0]; r_arm <= 1'b0;
      end else if (w_rx_byte == 8'hFF) begin
        r_rsp1 <= 8'hAA; r_rsp_n <= 2'd2; r_leds <= '0;
      end else if (w_rx_byte == 8'hED) r_arm <= 1'b1;
    end else if (w_pop && r_src_rsp) begin
      r_rsp0 <= r_rsp1; r_rsp_n <= r_rsp_n - 2'd1;
    end
  end

  // key event capture: whole sequence lands in the FIFO at once, or not at all
  always_comb begin
    w_len  = 2'd1;
    w_seq0 = ps2_key[7:0];
    w_seq1 = ps2_key[7:0];
    w_seq2 = ps2_key[7:0];
    case (ps2_key[9:8])
      2'b11: begin w_len = 2'd2; w_seq0 = 8'hE0; end
      2'b00: begin w_len = 2'd2; w_seq0 = 8'hF0; end
      2'b01: begin w_len = 2'd3; w_seq0 = 8'hE0; w_seq1 = 8'hF0; end
      default: ;
    endcase
  end

  assign w_evt  = r_tog_vld && (ps2_key[10] != r_tog);
  assign w_free = (AW+1)'(FIFO_DEPTH) - r_cnt;
  assign w_push = w_evt && (w_free >= (AW+1)'(w_len)) && !w_flush;
  assign w_drop = w_evt && (w_free <  (AW+1)'(w_len)) && !w_flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tog <= 1'b0; r_tog_vld <= 1'b0; r_ovf <= 1'b0;
      r_wp <= '0; r_rp <= '0; r_cnt <= '0;
    end else begin
      r_tog     <= ps2_key[10];
      r_tog_vld <= 1'b1;
      r_ovf     <= w_drop;
      if (w_flush) begin
        r_rp <= r_wp; r_cnt <= '0;
      end else begin
        if (w_push)     r_wp <= r_wp + AW'(w_len);
        if (w_pop_fifo) r_rp <= r_rp + 1'b1;
        r_cnt <= r_cnt + (w_push ? (AW+1)'(w_len) : '0) - (w_pop_fifo ? (AW+1)'(1) : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= w_seq0;
      if (w_len != 2'd1) r_mem[r_wp + AW'(1)] <= w_seq1;
      if (w_len == 2'd3) r_mem[r_wp + AW'(2)] <= w_seq2;
    end
  end
endmodule

// File: tb/tb_ps2_kbd_device.sv
// tb_ps2_kbd_device: randomized self-checking bench for ps2_kbd_device with
// H = 10 clocks. Models the host side of the wired-AND bus and keeps a
// byte-level queue of the scancodes the keyboard is expected to send.
module tb_ps2_kbd_device;
  localparam int H     = 10;
  localparam int DEPTH = 16;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic        host_clk = 1'b1, host_dat = 1'b1;
  logic        ps2_clk_out, ps2_data_out, busy, overflow;
  logic [2:0]  leds;
  logic        line_clk, line_dat;

  assign line_clk = ps2_clk_out & host_clk;
  assign line_dat = ps2_data_out & host_dat;

  ps2_kbd_device #(.CLK_HZ(1000000), .PS2_HZ(50000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key),
    .ps2_clk_in(line_clk), .ps2_data_in(line_dat),
    .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out),
    .leds(leds), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;
  int ovf_cnt = 0;
  always @(negedge clk) if (overflow) ovf_cnt++;

  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  logic [2:0] exp_leds = '0;

  initial begin
    #900000;
    $display("FAIL watchdog: sim time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // toggle ps2_key and record the bytes a keyboard must emit (if they fit)
  task automatic send_key(input bit pressed, input bit ext, input logic [7:0] code,
                          output bit dropped);
    logic [7:0] seq[$];
    @(negedge clk);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    if (ext) seq.push_back(8'hE0);
    if (!pressed) seq.push_back(8'hF0);
    seq.push_back(code);
    dropped = (DEPTH - exp_q.size()) < seq.size();
    if (!dropped) foreach (seq[i]) exp_q.push_back(seq[i]);
    repeat (2) @(negedge clk);
  endtask

  // capture one device frame: line data at each clock falling edge
  task automatic rx_frame(output logic [10:0] bits, output int first, output int last,
                          output int gap_bad, output bit to);
    int t = 0, n = 0;
    logic prev;
    bits = '0; first = 0; last = 0; gap_bad = 0;
    prev = line_clk;
    while (n < 11 && t < 3000) begin
      @(negedge clk); t++;
      if (prev && !line_clk) begin
        bits[n] = line_dat;
        if (n == 0) first = cyc;
        else if (cyc - last != 2 * H) gap_bad++;
        last = cyc;
        n++;
      end
      prev = line_clk;
    end
    to = (n < 11);
  endtask

  // host-to-device transfer: request, clock out 8 data + parity + stop, check ACK
  task automatic host_send(input logic [7:0] b, input bit bad, output bit ack, output bit to);
    logic [9:0] bits;
    int t, k;
    logic prev;
    bits = {1'b1, (~^b) ^ bad, b};
    ack = 1'b0;
    t = 0;
    while (busy && t < 2000) begin @(negedge clk); t++; end
    @(negedge clk); host_clk = 1'b0;
    repeat (3 * H) @(negedge clk);
    host_dat = 1'b0;
    repeat (3) @(negedge clk);
    host_clk = 1'b1;
    k = 0; t = 0; prev = line_clk;
    while (k < 11 && t < 3000) begin
      @(negedge clk); t++;
      if (prev && !line_clk) begin
        if (k < 10) host_dat = bits[k];
        else begin repeat (3) @(negedge clk); ack = (line_dat == 1'b0); end
        k++;
      end
      prev = line_clk;
    end
    host_dat = 1'b1;
    to = (k < 11);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ps2_key = 11'h400;
    repeat (3) @(negedge clk);
    n_tests++; if ({ps2_clk_out, ps2_data_out} !== 2'b11) begin n_fail++;
      $display("FAIL reset_lines: got %b expected 11", {ps2_clk_out, ps2_data_out}); end
    n_tests++; if ({busy, overflow, leds} !== 5'b0) begin n_fail++;
      $display("FAIL reset_status: got %b expected 00000", {busy, overflow, leds}); end
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    n_tests++; if (busy !== 1'b0 || ps2_clk_out !== 1'b1) begin n_fail++;
      $display("FAIL reset_no_event: got busy=%b clk=%b expected 0 1", busy, ps2_clk_out); end
    n_tests++; if (ovf_cnt !== 0) begin n_fail++;
      $display("FAIL reset_ovf: got %0d expected 0", ovf_cnt); end
  endtask

  task automatic test_press;
    logic [10:0] bits; int f, l, g; bit to, d; logic [7:0] e;
    send_key(1'b1, 1'b0, 8'h1C, d);
    n_tests++; if (ps2_key !== 11'h21C) begin n_fail++;
      $display("FAIL press_stim: got %h expected 21c", ps2_key); end
    rx_frame(bits, f, l, g, to);
    e = exp_q.pop_front();
    n_tests++; if (to || bits !== {1'b1, ~^e, e, 1'b0}) begin n_fail++;
      $display("FAIL press_frame: got %b to=%0d expected %b", bits, to, {1'b1, ~^e, e, 1'b0}); end
    n_tests++; if (bits !== 11'b100_0011_1000) begin n_fail++;
      $display("FAIL press_bits: got %b expected 10000111000", bits); end
    n_tests++; if (g !== 0) begin n_fail++;
      $display("FAIL press_period: got %0d bad edges expected 0", g); end
  endtask

  task automatic test_ext_release;
    logic [10:0] bits; int f, l, g, pl; bit to, d; logic [7:0] e;
    repeat (5 * H) @(negedge clk);
    send_key(1'b0, 1'b1, 8'h75, d);
    pl = 0;
    for (int i = 0; i < 3; i++) begin
      rx_frame(bits, f, l, g, to);
      e = exp_q.pop_front();
      n_tests++; if (to || bits !== {1'b1, ~^e, e, 1'b0} || g != 0) begin n_fail++;
        $display("FAIL ext_rel_frame%0d: got %b to=%0d expected %b", i, bits, to, {1'b1, ~^e, e, 1'b0}); end
      if (i > 0) begin
        n_tests++; if (f - pl < 4 * H) begin n_fail++;
          $display("FAIL ext_rel_gap%0d: got %0d cycles expected >= %0d", i, f - pl, 4 * H); end
      end
      pl = l;
    end
  endtask

  task automatic test_inhibit;
    logic [10:0] bits; int f, l, g, t, k; bit to, d; logic prev; logic [7:0] e;
    t = 0; while (busy && t < 2000) begin @(negedge clk); t++; end
    send_key(1'b1, 1'b0, 8'($urandom_range(1, 255)), d);
    k = 0; t = 0; prev = line_clk;
    while (k < 4 && t < 2000) begin
      @(negedge clk); t++;
      if (prev && !line_clk) k++;
      prev = line_clk;
    end
    n_tests++; if (k != 4) begin n_fail++;
      $display("FAIL inhibit_start: got %0d edges expected 4", k); end
    host_clk = 1'b0;
    t = 0;
    while (!(ps2_clk_out && ps2_data_out && !busy) && t < 2 * H + 3) begin @(negedge clk); t++; end
    n_tests++; if (!(ps2_clk_out && ps2_data_out && !busy)) begin n_fail++;
      $display("FAIL inhibit_release: got clk=%b dat=%b busy=%b expected 1 1 0", ps2_clk_out, ps2_data_out, busy); end
    repeat (5 * H) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL inhibit_hold: got busy=%b expected 0", busy); end
    host_clk = 1'b1;
    rx_frame(bits, f, l, g, to);
    e = exp_q.pop_front();
    n_tests++; if (to || bits !== {1'b1, ~^e, e, 1'b0}) begin n_fail++;
      $display("FAIL inhibit_resend: got %b to=%0d expected %b", bits, to, {1'b1, ~^e, e, 1'b0}); end
  endtask

  // queue n events while the host inhibits, then drain and compare
  task automatic run_batch(input string name, input int n, input bit fixed);
    logic [10:0] bits; int f, l, g, t, drops, o0, cnt; bit to, d; logic [7:0] e;
    t = 0; while (busy && t < 3000) begin @(negedge clk); t++; end
    @(negedge clk); host_clk = 1'b0;
    repeat (3) @(negedge clk);
    drops = 0; o0 = ovf_cnt;
    for (int i = 0; i < n; i++) begin
      if (fixed) send_key(1'b0, 1'b1, 8'($urandom_range(1, 255)), d);
      else send_key(1'($urandom), 1'($urandom), 8'($urandom), d);
      drops += d;
    end
    repeat (4) @(negedge clk);
    n_tests++; if (ovf_cnt - o0 != drops) begin n_fail++;
      $display("FAIL %s_overflow: got %0d pulses expected %0d", name, ovf_cnt - o0, drops); end
    host_clk = 1'b1;
    cnt = exp_q.size();
    for (int i = 0; i < cnt; i++) begin
      rx_frame(bits, f, l, g, to);
      e = exp_q.pop_front();
      n_tests++; if (to || bits !== {1'b1, ~^e, e, 1'b0}) begin n_fail++;
        $display("FAIL %s_byte%0d: got %b to=%0d expected %b", name, i, bits, to, {1'b1, ~^e, e, 1'b0}); end
    end
    repeat (6 * H) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL %s_drained: got busy=%b expected 0", name, busy); end
  endtask

  task automatic test_overflow;
    run_batch("overflow", 6, 1'b1);
  endtask

  task automatic test_random;
    for (int r = 0; r < 3; r++) run_batch($sformatf("random%0d", r), $urandom_range(2, 6), 1'b0);
  endtask

  task automatic test_leds;
    logic [10:0] bits; int f, l, g; bit to, ack;
    logic [7:0] cmds[2];
    cmds[0] = 8'hED; cmds[1] = 8'h07;
    for (int i = 0; i < 2; i++) begin
      host_send(cmds[i], 1'b0, ack, to);
      n_tests++; if (to || !ack) begin n_fail++;
        $display("FAIL leds_ack%0d: got ack=%0d to=%0d expected 1 0", i, ack, to); end
      rx_frame(bits, f, l, g, to);
      n_tests++; if (to || bits[8:1] !== 8'hFA) begin n_fail++;
        $display("FAIL leds_resp%0d: got %h expected fa", i, bits[8:1]); end
    end
    exp_leds = cmds[1][2:0];
    n_tests++; if (leds !== exp_leds) begin n_fail++;
      $display("FAIL leds_value: got %b expected %b", leds, exp_leds); end
  endtask

  task automatic test_reset_cmd;
    logic [10:0] bits; int f, l, g, t, k; bit to, ack, d; logic prev;
    logic [7:0] rsp[2];
    host_send(8'hFF, 1'b1, ack, to);
    n_tests++; if (to || !ack) begin n_fail++;
      $display("FAIL badpar_ack: got ack=%0d to=%0d expected 1 0", ack, to); end
    rx_frame(bits, f, l, g, to);
    n_tests++; if (to || bits[8:1] !== 8'hFE) begin n_fail++;
      $display("FAIL badpar_resp: got %h expected fe", bits[8:1]); end
    n_tests++; if (leds !== exp_leds) begin n_fail++;
      $display("FAIL badpar_leds: got %b expected %b", leds, exp_leds); end
    t = 0; while (busy && t < 2000) begin @(negedge clk); t++; end
    @(negedge clk); host_clk = 1'b0;
    send_key(1'b0, 1'b1, 8'h6B, d);
    send_key(1'b1, 1'b0, 8'h29, d);
    exp_q.delete();
    exp_leds = '0;
    host_send(8'hFF, 1'b0, ack, to);
    n_tests++; if (to || !ack) begin n_fail++;
      $display("FAIL ff_ack: got ack=%0d to=%0d expected 1 0", ack, to); end
    rsp[0] = 8'hFA; rsp[1] = 8'hAA;
    for (int i = 0; i < 2; i++) begin
      rx_frame(bits, f, l, g, to);
      n_tests++; if (to || bits !== {1'b1, ~^rsp[i], rsp[i], 1'b0}) begin n_fail++;
        $display("FAIL ff_resp%0d: got %b expected %b", i, bits, {1'b1, ~^rsp[i], rsp[i], 1'b0}); end
    end
    k = 0; prev = line_clk;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (prev && !line_clk) k++;
      prev = line_clk;
    end
    n_tests++; if (k != 0) begin n_fail++;
      $display("FAIL ff_flushed: got %0d extra edges expected 0", k); end
    n_tests++; if (leds !== exp_leds) begin n_fail++;
      $display("FAIL ff_leds: got %b expected %b", leds, exp_leds); end
  endtask

  task automatic test_reset_midframe;
    int t, k; bit d; logic prev;
    t = 0; while (busy && t < 2000) begin @(negedge clk); t++; end
    send_key(1'b1, 1'b1, 8'($urandom), d);
    k = 0; t = 0; prev = line_clk;
    while (k < 3 && t < 2000) begin
      @(negedge clk); t++;
      if (prev && !line_clk) k++;
      prev = line_clk;
    end
    reset_n = 1'b0;
    #1;
    n_tests++; if ({ps2_clk_out, ps2_data_out, busy} !== 3'b110) begin n_fail++;
      $display("FAIL midreset_lines: got %b expected 110", {ps2_clk_out, ps2_data_out, busy}); end
    exp_q.delete();
    @(negedge clk); reset_n = 1'b1;
    k = 0; prev = line_clk;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (prev && !line_clk) k++;
      prev = line_clk;
    end
    n_tests++; if (k != 0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL midreset_lost: got %0d edges busy=%b expected 0 0", k, busy); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_ext_release();
    test_inhibit();
    test_overflow();
    test_random();
    test_leds();
    test_reset_cmd();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
